// File: rtl/pll_reset_ctrl.sv
// PLL power-up/fault sequencer: PLL reset pulse, lock wait with timeout, lock qualification, system reset release.
// Optional macro PLL_RESET_CTRL_AUTO_RELOCK_EN: lock loss while running reruns the sequence instead of parking in FAULT.
module pll_reset_ctrl #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int RETRY_CNT_WIDTH     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_locked,
    input  logic                       i_relock,
    output logic                       o_pll_rst,
    output logic                       o_sys_rst,
    output logic                       o_ready,
    output logic [RETRY_CNT_WIDTH-1:0] o_retry_count
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CNT = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    // The WAIT_LOCK cycle that first sees lock counts as the first stable sample.
    localparam logic [CNT_W-1:0] STABLE_LAST  =
        CNT_W'((LOCK_STABLE_CYCLES > 1) ? (LOCK_STABLE_CYCLES - 2) : 0);

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
`ifdef PLL_RESET_CTRL_AUTO_RELOCK_EN
        ST_RUNNING   = 3'd3
`else
        ST_RUNNING   = 3'd3,
        ST_FAULT     = 3'd4
`endif
    } state_t;

    // Output decode {pll_rst, sys_rst, ready}, applied to the state being entered.
    function automatic logic [2:0] f_outs(input state_t s);
        case (s)
            ST_WAIT_LOCK: f_outs = 3'b010;
            ST_STABILIZE: f_outs = 3'b010;
            ST_RUNNING:   f_outs = 3'b001;
`ifndef PLL_RESET_CTRL_AUTO_RELOCK_EN
            ST_FAULT:     f_outs = 3'b010;
`endif
            default:      f_outs = 3'b110;
        endcase
    endfunction

    state_t                     r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_lock_meta;
    logic                       r_lock_s;
    logic                       r_pll_rst;
    logic                       r_sys_rst;
    logic                       r_ready;
    logic [RETRY_CNT_WIDTH-1:0] r_retry_cnt;

    logic                       w_relock;
    logic [RETRY_CNT_WIDTH-1:0] w_retry_inc;
    logic [CNT_W-1:0]           w_cnt_inc;

    assign w_relock    = i_relock && (r_state != ST_PLL_RESET);
    assign w_retry_inc = (&r_retry_cnt) ? r_retry_cnt : (r_retry_cnt + RETRY_CNT_WIDTH'(1));
    assign w_cnt_inc   = r_cnt + CNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_state     <= ST_PLL_RESET;
            r_cnt       <= '0;
            r_retry_cnt <= '0;
            {r_pll_rst, r_sys_rst, r_ready} <= f_outs(ST_PLL_RESET);
        end else begin
            r_lock_meta <= i_locked;
            r_lock_s    <= r_lock_meta;
            if (w_relock) begin
                // A lock loss in the same cycle as a relock is still counted.
                if ((r_state == ST_RUNNING) && !r_lock_s) begin
                    r_retry_cnt <= w_retry_inc;
                end
                r_state <= ST_PLL_RESET;
                r_cnt   <= '0;
                {r_pll_rst, r_sys_rst, r_ready} <= f_outs(ST_PLL_RESET);
            end else begin
                case (r_state)
                    ST_PLL_RESET: begin
                        if (r_cnt == PLL_LAST) begin
                            r_state <= ST_WAIT_LOCK;
                            r_cnt   <= '0;
                            {r_pll_rst, r_sys_rst, r_ready} <= f_outs(ST_WAIT_LOCK);
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (r_lock_s) begin
                            r_state <= ST_STABILIZE;
                            r_cnt   <= '0;
                            {r_pll_rst, r_sys_rst, r_ready} <= f_outs(ST_STABILIZE);
                        end else if (r_cnt == TIMEOUT_LAST) begin
                            r_retry_cnt <= w_retry_inc;
                            r_state     <= ST_PLL_RESET;
                            r_cnt       <= '0;
                            {r_pll_rst, r_sys_rst, r_ready} <= f_outs(ST_PLL_RESET);
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    ST_STABILIZE: begin
                        if (!r_lock_s) begin
                            r_state <= ST_WAIT_LOCK;
                            r_cnt   <= '0;
                            {r_pll_rst, r_sys_rst, r_ready} <= f_outs(ST_WAIT_LOCK);
                        end else if (r_cnt == STABLE_LAST) begin
                            r_state <= ST_RUNNING;
                            r_cnt   <= '0;
                            {r_pll_rst, r_sys_rst, r_ready} <= f_outs(ST_RUNNING);
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    ST_RUNNING: begin
                        if (!r_lock_s) begin
                            r_retry_cnt <= w_retry_inc;
                            r_cnt       <= '0;
`ifdef PLL_RESET_CTRL_AUTO_RELOCK_EN
                            r_state <= ST_PLL_RESET;
                            {r_pll_rst, r_sys_rst, r_ready} <= f_outs(ST_PLL_RESET);
`else
                            r_state <= ST_FAULT;
                            {r_pll_rst, r_sys_rst, r_ready} <= f_outs(ST_FAULT);
`endif
                        end
                    end
`ifndef PLL_RESET_CTRL_AUTO_RELOCK_EN
                    ST_FAULT: begin
                        r_state <= ST_FAULT;
                    end
`endif
                    default: begin
                        r_state <= ST_PLL_RESET;
                        r_cnt   <= '0;
                        {r_pll_rst, r_sys_rst, r_ready} <= f_outs(ST_PLL_RESET);
                    end
                endcase
            end
        end
    end

    assign o_pll_rst     = r_pll_rst;
    assign o_sys_rst     = r_sys_rst;
    assign o_ready       = r_ready;
    assign o_retry_count = r_retry_cnt;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed testbench for pll_reset_ctrl with small parameters (reset 4, stable 8, timeout 32, 4-bit retry count).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pll_reset_ctrl;

    logic       clk;
    logic       rstN;
    logic       locked;
    logic       relock;
    logic       pllRst;
    logic       sysRst;
    logic       ready;
    logic [3:0] retryCount;

    int checks = 0;
    int errors = 0;

    pll_reset_ctrl #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .RETRY_CNT_WIDTH     (4)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_locked      (locked),
        .i_relock      (relock),
        .o_pll_rst     (pllRst),
        .o_sys_rst     (sysRst),
        .o_ready       (ready),
        .o_retry_count (retryCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic rl);
        rstN   = r;
        locked = l;
        relock = rl;
    endtask

    task automatic checkOutput(input string tag, input logic expPll, input logic expSys,
                               input logic expReady, input int expRetry);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {pllRst, sysRst, ready, retryCount};
        exp = {expPll, expSys, expReady, 4'(expRetry)};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed pll/sys/rdy/retry=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                   tag, obs[6], obs[5], obs[4], obs[3:0], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(3);
        checkOutput("reset", 1, 1, 0, 0);

        // Nominal bring-up: PLL reset for 4 clocks, lock raised 10 clocks after release.
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(3);
        checkOutput("pr_hold", 1, 1, 0, 0);
        tick(1);
        checkOutput("pr_end", 0, 1, 0, 0);
        tick(6);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(9);
        checkOutput("stab_hold", 0, 1, 0, 0);
        tick(1);
        checkOutput("running", 0, 0, 1, 0);
        tick(2);
        checkOutput("running_hold", 0, 0, 1, 0);

        // Relock from RUNNING, then a relock during PLL_RESET must be ignored.
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("relock_run", 1, 1, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(2);
        checkOutput("relock_ign_hold", 1, 1, 0, 0);
        tick(1);
        checkOutput("relock_ign_end", 0, 1, 0, 0);
        tick(8);
        checkOutput("rerun", 0, 0, 1, 0);

        // Lock loss while running, seen through the 2-flop synchronizer.
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(2);
        checkOutput("loss_pre", 0, 0, 1, 0);
        tick(1);
`ifdef PLL_RESET_CTRL_AUTO_RELOCK_EN
        checkOutput("loss_rerun", 1, 1, 0, 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
`else
        checkOutput("fault", 0, 1, 0, 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(6);
        checkOutput("fault_sticky", 0, 1, 0, 1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("fault_relock", 1, 1, 0, 1);
`endif
        tick(3);
        checkOutput("seq_hold", 1, 1, 0, 1);
        tick(1);
        checkOutput("seq_wait", 0, 1, 0, 1);
        tick(8);
        checkOutput("seq_run", 0, 0, 1, 1);

        // Relock keeps the retry count; reset mid-STABILIZE clears everything.
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("relock_keep", 1, 1, 0, 1);
        tick(6);
        checkOutput("stab_mid", 0, 1, 0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(1);
        checkOutput("reset_mid", 1, 1, 0, 0);
        tick(1);

        // Unstable lock: high 5 clocks, low 1, then high; 8 clean synced clocks required.
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(4);
        checkOutput("t3_wait", 0, 1, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(2);
        checkOutput("glitch_wait", 0, 1, 0, 0);
        tick(7);
        checkOutput("unstable_hold", 0, 1, 0, 0);
        tick(1);
        checkOutput("unstable_run", 0, 0, 1, 0);

        // Timeouts: PLL reset re-pulses every 36 clocks, retry count saturates at 15.
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(35);
        checkOutput("to_pre", 0, 1, 0, 0);
        tick(1);
        checkOutput("timeout_1", 1, 1, 0, 1);
        tick(3);
        checkOutput("to_pr_hold", 1, 1, 0, 1);
        tick(1);
        checkOutput("to_pr_end", 0, 1, 0, 1);
        tick(31);
        checkOutput("to_2_pre", 0, 1, 0, 1);
        tick(1);
        checkOutput("timeout_2", 1, 1, 0, 2);
        for (int k = 3; k <= 15; k++) begin
            tick(36);
            checkOutput($sformatf("timeout_%0d", k), 1, 1, 0, k);
        end
        tick(36);
        checkOutput("timeout_sat", 1, 1, 0, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
